uart_word_tx: RTL and testbench
===============================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5, meaning clocks per serial bit (5 clocks = 50 time units at the 10-unit clock period).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning word FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port send_data, input, 32 bits: word from the core.
REQ-006 SHALL have port send_enable, input, 1 bit: a one-cycle strobe that writes send_data.
REQ-007 SHALL have port rs_tx, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port full, output, 1 bit: the FIFO holds FIFO_DEPTH words.
REQ-009 SHALL have port busy, output, 1 bit: the FIFO is non-empty or a frame is in progress.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped.

Function
REQ-011 SHALL accept send_data on a rising edge with send_enable=1 and full=0; with full=1 the word is dropped and overflow is set on that edge.
REQ-012 SHALL NOT let a pop on the same edge make room for a push; full is sampled before that edge.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP, plus a 2-bit byte index and a bit counter of width clog2(CLKS_PER_BIT).
REQ-014 IDLE: rs_tx=1; when the FIFO is non-empty, SHALL pop the head word, set byte index 0 and go to START.
REQ-015 SHALL serialise each word as 4 frames, byte 0 (bits 7:0) first, byte 3 last.
REQ-016 Frame: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-017 STOP end: byte index <3 -> START of the next byte with no idle gap; byte index 3 and FIFO non-empty -> pop and go to START directly; otherwise -> IDLE.
REQ-018 rs_tx SHALL be registered; a word written at edge N into an empty FIFO while IDLE drives rs_tx=0 from edge N+2.
REQ-019 One word SHALL occupy 40*CLKS_PER_BIT cycles (44*CLKS_PER_BIT with parity).
REQ-020 full and busy SHALL be combinational from FIFO count and FSM state.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be one bit wider than the pointers.

Reset
REQ-022 On reset=1, asynchronously: rs_tx=1, FSM=IDLE, FIFO emptied, full=0, busy=0, overflow=0, all counters 0.
REQ-023 Reset mid-frame SHALL abort the frame immediately with rs_tx high; after reset deasserts, transmission of any word starts only from a new send_enable.
REQ-024 overflow SHALL clear only on reset.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and send even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-026 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, BYTES_PER_WORD=4 and the frame-length constants.
REQ-028 Sub-module word_fifo (32-bit, parameter FIFO_DEPTH, push/pop/full/empty) SHALL hold the buffer; uart_word_tx instantiates it once.

Verification
REQ-029 Write 0x00000059 once, then sample rs_tx mid-bit -> bit sequence 0,1,0,0,1,1,0,1,0,1 (0x59 LSB first), then three frames 0,00000000,1, with busy low after 200 cycles.
REQ-030 Write 0x00000001 and 0x00000002 on consecutive cycles -> 8 back-to-back frames (01,00,00,00,02,00,00,00) with no idle cycle between them.
REQ-031 Write 6 words on consecutive cycles with FIFO_DEPTH=4 -> the first word is popped into the FSM, words 2-5 are buffered, full=1, word 6 is dropped, overflow=1, and exactly 5 words appear on rs_tx.
REQ-032 Assert reset during byte 1 of 0x12345678 -> rs_tx=1 within the same cycle, busy=0, and rs_tx stays at 1 until the next send_enable.
REQ-033 With UART_TX_PARITY_EN, write 0x00000759 -> byte 0x59 gets parity 0 and byte 0x07 gets parity 1; each frame is 11 bits (55 cycles).
REQ-034 Write 0x00000059 with send_enable at edge N -> rs_tx=1 through edge N+1 and rs_tx=0 from edge N+2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
// Optional even-parity bit per frame: define UART_TX_PARITY_EN.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = DATA_BITS * BYTES_PER_WORD;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    // Serial bits per byte frame (start + data + optional parity + stop) and per word
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;
    localparam int unsigned WORD_BITS  = FRAME_BITS * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/word_fifo.sv
// Small word FIFO buffering 32-bit words ahead of the serialiser.
// FIFO_DEPTH must be a power of two, at least 2; pointers wrap naturally.
module word_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // Status is decoded straight from the occupancy count
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: 32-bit words are queued in a FIFO and sent as
// four byte frames, byte 0 first, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] send_data,
    input  logic              send_enable,
    output logic              rs_tx,
    output logic              full,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [WORD_W-1:0]    word_q;
    logic [1:0]           byte_idx;
    logic [2:0]           bit_idx;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] cur_byte;
    logic                 bit_end;
    logic [WORD_W-1:0]    fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    // Full is taken before the edge, so a same-edge pop never frees room for a push
    assign fifo_push = send_enable && !fifo_full;
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) ||
                        ((state == STOP) && bit_end && (byte_idx == LAST_BYTE)));
    assign bit_end   = (bit_cnt == CNT_LAST);
    assign cur_byte  = word_q[{byte_idx, 3'b000} +: DATA_BITS];
    assign full      = fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);

    word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (send_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (send_enable && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Frame sequencer; rs_tx is registered from the current state so the line
    // trails the state by one clock, and each bit is held CLKS_PER_BIT clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_q   <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            rs_tx    <= 1'b1;
        end else begin
            case (state)
                START:   rs_tx <= 1'b0;
                DATA:    rs_tx <= cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
                PARITY:  rs_tx <= even_parity(cur_byte);
`endif
                default: rs_tx <= 1'b1;
            endcase

            if (state == IDLE || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        word_q   <= fifo_rdata;
                        byte_idx <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= START;
                        end else if (!fifo_empty) begin
                            word_q   <= fifo_rdata;
                            byte_idx <= '0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with hand-derived frame expectations.
module tb_uart_word_tx;

    localparam int unsigned C = 5;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] send_data = '0;
    logic        send_enable = 1'b0;
    logic        rs_tx;
    logic        full;
    logic        busy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] cap [0:19];
    logic [31:0] words6 [0:5] = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788,
                                  32'h99AABBCC, 32'hDDEEFF00, 32'hCAFEF00D};

    uart_word_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .send_data   (send_data),
        .send_enable (send_enable),
        .rs_tx       (rs_tx),
        .full        (full),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line pattern of one byte frame, bit i = i-th bit on the wire
    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        send_data   = w;
        send_enable = 1'b1;
        @(negedge clk);
        send_enable = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (rs_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(ok), 32'd1);
    endtask

    // Samples contiguous frames mid-bit; any idle gap misaligns later frames
    task automatic capture(input int nfr);
        bit ok;
        wait_start(ok);
        if (ok) begin
            for (int f = 0; f < nfr; f++) begin
                cap[f] = '0;
                for (int b = 0; b < int'(FB); b++) begin
                    repeat ((f == 0 && b == 0) ? C / 2 : C) @(posedge clk);
                    #1;
                    cap[f][b] = rs_tx;
                end
            end
        end
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_byte%0d", tag, k), 32'(cap[base + k]), 32'(frame_of(w[8*k +: 8])));
        end
    endtask

    initial begin
        bit ok;
        int lows;
        int busy_hi;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rs_tx", 32'(rs_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Write-to-start latency: idle through N+1, start bit from N+2
        @(negedge clk);
        send_data   = 32'h00000059;
        send_enable = 1'b1;
        @(posedge clk);
        #1;
        check("lat_edge_n", 32'(rs_tx), 32'd1);
        @(negedge clk);
        send_enable = 1'b0;
        @(posedge clk);
        #1;
        check("lat_edge_n1", 32'(rs_tx), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("lat_edge_n2", 32'(rs_tx), 32'd0);
        // Word lasts exactly 200 clocks from the pop at N+1
        repeat (198) @(posedge clk);
        #1;
        check("busy_at_200", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("idle_at_201", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);

        // Single word 0x59: frames 0x59,00,00,00
        send_word(32'h00000059);
        capture(4);
        check("w59_hand_frame", 32'(cap[0]), 32'(frame_of(8'h59)));
        check_word("w59", 0, 32'h00000059);
        repeat (C) @(posedge clk);
        #1;
        check("w59_busy_done", 32'(busy), 32'd0);
        check("w59_line_idle", 32'(rs_tx), 32'd1);

        // Two words back to back, no idle gap across the word boundary
        @(negedge clk);
        send_data   = 32'h00000001;
        send_enable = 1'b1;
        @(negedge clk);
        send_data   = 32'h00000002;
        @(negedge clk);
        send_enable = 1'b0;
        capture(8);
        check_word("b2b_w1", 0, 32'h00000001);
        check_word("b2b_w2", 4, 32'h00000002);
        repeat (C) @(posedge clk);
        #1;
        check("b2b_busy_done", 32'(busy), 32'd0);

        // Six writes into a depth-4 FIFO: one in flight, four buffered, one dropped
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (i == 5) begin
                        check("ovf_full_before", 32'(full), 32'd1);
                        check("ovf_clear_before", 32'(overflow), 32'd0);
                    end
                    send_data   = words6[i];
                    send_enable = 1'b1;
                end
                @(negedge clk);
                send_enable = 1'b0;
                check("ovf_set", 32'(overflow), 32'd1);
                check("ovf_full_after", 32'(full), 32'd1);
            end
            capture(20);
        join
        for (int w = 0; w < 5; w++) begin
            check_word($sformatf("ovf_w%0d", w), 4 * w, words6[w]);
        end
        repeat (C) @(posedge clk);
        #1;
        check("ovf_no_sixth", 32'(busy), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during byte 1 of 0x12345678
        send_word(32'h12345678);
        wait_start(ok);
        repeat (52) @(posedge clk);
        #1;
        check("rst_mid_pre", 32'(rs_tx), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", 32'(rs_tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows    = 0;
        busy_hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (rs_tx !== 1'b1) lows++;
            if (busy !== 1'b0) busy_hi++;
        end
        check("post_rst_line_low", 32'(lows), 32'd0);
        check("post_rst_busy", 32'(busy_hi), 32'd0);

        // Fresh word after reset
        send_word(32'h000000A5);
        capture(4);
        check_word("post_rst", 0, 32'h000000A5);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x59 -> 0, 0x07 -> 1
        repeat (2 * C) @(posedge clk);
        send_word(32'h00000759);
        capture(4);
        check("par_59", 32'(cap[0][9]), 32'd0);
        check("par_07", 32'(cap[1][9]), 32'd1);
        check_word("par", 0, 32'h00000759);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
